mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter p_WORD_LEN, default 16, data word width.
REQ-002 Parameter p_ADDR_LEN, default 16, address width.
REQ-003 Parameter p_DATA_MEM_SIZE, default 1024, implemented data-memory words (power of 2).
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 reqN  in  1  (N=0,1) request; held with weN/addrN/wdataN stable until gntN seen.
REQ-007 weN  in  1  1 = write, 0 = read.
REQ-008 addrN  in  p_ADDR_LEN  request address.
REQ-009 wdataN  in  p_WORD_LEN  write data.
REQ-010 gntN  out  1  high for exactly the EXEC cycle of port N's transaction.
REQ-011 rvalidN  out  1  one-cycle pulse, read data valid on rdataN.
REQ-012 rdataN  out  p_WORD_LEN  registered read data; holds value between reads.
REQ-013 errN  out  1  one-cycle pulse with gnt-following cycle when accepted address >= p_DATA_MEM_SIZE.
REQ-014 mem_address  out  p_ADDR_LEN  to data memory address.
REQ-015 mem_dataIn  out  p_WORD_LEN  to data memory write data.
REQ-016 mem_writeEn  out  1  to data memory write enable (memory writes on negedge).
REQ-017 mem_dataOut  in  p_WORD_LEN  asynchronous read data from data memory.

Function
REQ-018 FSM states IDLE, EXEC; reset state IDLE.
REQ-019 IDLE, no req: stay IDLE, all outputs idle.
REQ-020 IDLE, any req at posedge: pick winner, latch its we/addr/wdata into txn registers, record owner, go EXEC.
REQ-021 Arbitration: single requester wins; both requesting -> port not recorded as last_winner wins (round-robin).
REQ-022 last_winner updates to owner on EXEC exit; reset value 1 so port 0 wins first contested cycle.
REQ-023 EXEC: mem_address = latched addr, mem_dataIn = latched wdata, mem_writeEn = latched we AND ~rst; gnt[owner]=1; unconditional return to IDLE next posedge.
REQ-024 Outside EXEC: mem_writeEn=0, mem_address=0, mem_dataIn=0.
REQ-025 Requests not sampled in EXEC; peak throughput one transaction per 2 cycles.
REQ-026 Read: rdata[owner] <= mem_dataOut at EXEC-exit posedge; rvalid[owner]=1 for the following cycle (latency 2 cycles accept->rvalid).
REQ-027 Write: no rvalid; rdataN unchanged.
REQ-028 Out-of-range address (upper bits nonzero): write suppressed (mem_writeEn=0), read returns 0 with rvalid, errN pulses with rvalid timing.
REQ-029 Requester deasserting req in IDLE before sampling: no transaction; no partial acceptance.
REQ-030 gnt0 and gnt1 never simultaneously high; rvalid0/rvalid1 never simultaneously high.

Reset
REQ-031 rst in any state: next state IDLE, last_winner=1, txn registers 0, rdataN=0, gntN/rvalidN/errN=0.
REQ-032 rst during EXEC: mem_writeEn forced 0 that cycle; aborted transaction produces no rvalid/err, no round-robin update.
REQ-033 Reset has priority over simultaneous requests.

Structure
REQ-034 Shared definitions include (guarded): FSM state encodings, port index constants, default word/address widths.
REQ-035 One sub-module arb_rr2: combinational 2-way round-robin picker (req[1:0], last_winner -> grant index, any).

Verification
REQ-036 Reset then req0 write addr 0x0005 data 0xBEEF -> gnt0 one cycle after accept, mem_writeEn=1 that cycle, memory[5]=0xBEEF.
REQ-037 req1 read addr 0x0005 after REQ-036 -> gnt1, rvalid1 next cycle, rdata1=0xBEEF, rvalid0 stays 0.
REQ-038 req0 and req1 held continuously, reads from 0x0001/0x0002 -> grants alternate 0,1,0,1, one per 2 cycles, port 0 first after reset.
REQ-039 req0 write addr 0x0400 (size 1024) data 0x1234 -> mem_writeEn=0, err0 pulse; subsequent read 0x0400 -> rdata0=0, rvalid0 and err0 pulse.
REQ-040 rst asserted in EXEC of write 0x0007/0xAAAA -> mem_writeEn=0, FSM IDLE, no rvalid/err, next contested grant goes to port 0.
REQ-041 Random traffic both ports, scoreboard model -> read data matches model, gnt/rvalid mutually exclusive every cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encodings,
// port index constants, default widths and the round-robin pick function.
`ifndef MEM_ARBITER_PKG_SV
`define MEM_ARBITER_PKG_SV

package mem_arbiter_pkg;

  localparam int c_DEF_WORD_LEN      = 16;
  localparam int c_DEF_ADDR_LEN      = 16;
  localparam int c_DEF_DATA_MEM_SIZE = 1024;

  localparam logic c_PORT0 = 1'b0;
  localparam logic c_PORT1 = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // Two-way round-robin choice: a lone requester wins; on contention the
  // port that did not win last time is chosen.
  function automatic logic rr2_pick(input logic [1:0] req, input logic last_winner);
    logic pick;
    case (req)
      2'b01:   pick = c_PORT0;
      2'b10:   pick = c_PORT1;
      2'b11:   pick = ~last_winner;
      default: pick = c_PORT0;
    endcase
    return pick;
  endfunction

endpackage

`endif

// File: rtl/mem_arbiter_arb_rr2.sv
// Combinational two-way round-robin picker used by mem_arbiter.
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic       grant_idx,
  output logic       any
);

  // Pick the winning port index and flag whether anyone is requesting.
  always_comb begin
    grant_idx = rr2_pick(req, last_winner);
    any       = |req;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each accepted request occupies one EXEC cycle; reads return data two
// cycles after acceptance, out-of-range accesses raise a one-cycle error.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int p_WORD_LEN      = c_DEF_WORD_LEN,
  parameter int p_ADDR_LEN      = c_DEF_ADDR_LEN,
  parameter int p_DATA_MEM_SIZE = c_DEF_DATA_MEM_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [p_ADDR_LEN-1:0] addr0,
  input  logic [p_WORD_LEN-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [p_ADDR_LEN-1:0] addr1,
  input  logic [p_WORD_LEN-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [p_WORD_LEN-1:0] rdata0,
  output logic [p_WORD_LEN-1:0] rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic [p_ADDR_LEN-1:0] mem_address,
  output logic [p_WORD_LEN-1:0] mem_dataIn,
  output logic                  mem_writeEn,
  input  logic [p_WORD_LEN-1:0] mem_dataOut
);

  // Address bits that actually index the implemented memory.
  localparam int c_IDX_LEN = $clog2(p_DATA_MEM_SIZE);

  state_e                state_q, state_d;
  logic                  last_winner_q, last_winner_d;
  logic                  owner_q, owner_d;
  logic                  txn_we_q, txn_we_d;
  logic                  txn_oor_q, txn_oor_d;
  logic [p_ADDR_LEN-1:0] txn_addr_q, txn_addr_d;
  logic [p_WORD_LEN-1:0] txn_wdata_q, txn_wdata_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic                  err0_q, err0_d;
  logic                  err1_q, err1_d;
  logic [p_WORD_LEN-1:0] rdata0_q, rdata0_d;
  logic [p_WORD_LEN-1:0] rdata1_q, rdata1_d;

  logic                  grant_idx_s;
  logic                  any_req_s;
  logic                  sel_we_s;
  logic                  sel_oor_s;
  logic [p_ADDR_LEN-1:0] sel_addr_s;
  logic [p_WORD_LEN-1:0] sel_wdata_s;
  logic [p_WORD_LEN-1:0] rd_value_s;
  logic                  exec_s;

  arb_rr2 u_arb (
    .req         ({req1, req0}),
    .last_winner (last_winner_q),
    .grant_idx   (grant_idx_s),
    .any         (any_req_s)
  );

  // Select the winning port's request fields and classify its address.
  always_comb begin
    if (grant_idx_s == c_PORT1) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
    sel_oor_s = ((sel_addr_s >> c_IDX_LEN) != '0);
  end

  // Out-of-range reads return zero instead of whatever the memory aliases to.
  always_comb begin
    if (txn_oor_q) begin
      rd_value_s = '0;
    end else begin
      rd_value_s = mem_dataOut;
    end
  end

  // Next-state and next-output logic for the IDLE/EXEC transaction FSM.
  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    owner_d       = owner_q;
    txn_we_d      = txn_we_q;
    txn_oor_d     = txn_oor_q;
    txn_addr_d    = txn_addr_q;
    txn_wdata_d   = txn_wdata_q;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
    err0_d        = 1'b0;
    err1_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d     = ST_EXEC;
          owner_d     = grant_idx_s;
          txn_we_d    = sel_we_s;
          txn_oor_d   = sel_oor_s;
          txn_addr_d  = sel_addr_s;
          txn_wdata_d = sel_wdata_s;
          // The grant flop is loaded here so it is high exactly in EXEC.
          gnt0_d      = (grant_idx_s == c_PORT0);
          gnt1_d      = (grant_idx_s == c_PORT1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d       = ST_IDLE;
        last_winner_d = owner_q;
        if (owner_q == c_PORT1) begin
          err1_d = txn_oor_q;
          if (!txn_we_q) begin
            rdata1_d  = rd_value_s;
            rvalid1_d = 1'b1;
          end else begin
            rdata1_d  = rdata1_q;
          end
        end else begin
          err0_d = txn_oor_q;
          if (!txn_we_q) begin
            rdata0_d  = rd_value_s;
            rvalid0_d = 1'b1;
          end else begin
            rdata0_d  = rdata0_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_winner_q <= c_PORT1;
      owner_q       <= c_PORT0;
      txn_we_q      <= 1'b0;
      txn_oor_q     <= 1'b0;
      txn_addr_q    <= '0;
      txn_wdata_q   <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      owner_q       <= owner_d;
      txn_we_q      <= txn_we_d;
      txn_oor_q     <= txn_oor_d;
      txn_addr_q    <= txn_addr_d;
      txn_wdata_q   <= txn_wdata_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      err0_q        <= err0_d;
      err1_q        <= err1_d;
    end
  end

  // Drive the memory bus only during EXEC; the write enable also drops
  // immediately when reset is asserted mid-transaction.
  always_comb begin
    exec_s = (state_q == ST_EXEC);
    if (exec_s) begin
      mem_address = txn_addr_q;
      mem_dataIn  = txn_wdata_q;
      mem_writeEn = txn_we_q & ~txn_oor_q & ~rst;
    end else begin
      mem_address = '0;
      mem_dataIn  = '0;
      mem_writeEn = 1'b0;
    end
  end

  // Port-side outputs come straight from registers.
  always_comb begin
    gnt0    = gnt0_q;
    gnt1    = gnt1_q;
    rvalid0 = rvalid0_q;
    rvalid1 = rvalid1_q;
    err0    = err0_q;
    err1    = err1_q;
    rdata0  = rdata0_q;
    rdata1  = rdata1_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and scoreboard-checked bench for mem_arbiter with a behavioural
// negedge-write / async-read data memory.
module tb_mem_arbiter;

  localparam int W = 16;
  localparam int A = 16;
  localparam int N = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [A-1:0] addr0 = '0, addr1 = '0;
  logic [W-1:0] wdata0 = '0, wdata1 = '0;
  logic         gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [W-1:0] rdata0, rdata1;
  logic [A-1:0] mem_address;
  logic [W-1:0] mem_dataIn, mem_dataOut;
  logic         mem_writeEn;

  logic [W-1:0] mem [0:N-1];
  logic [W-1:0] sb [0:15];
  logic [W-1:0] last_rd [0:1];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.p_WORD_LEN(W), .p_ADDR_LEN(A), .p_DATA_MEM_SIZE(N)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_writeEn(mem_writeEn), .mem_dataOut(mem_dataOut)
  );

  always #5 clk = ~clk;

  // Behavioural data memory.
  assign mem_dataOut = mem[mem_address[9:0]];
  always @(negedge clk) begin
    if (mem_writeEn) mem[mem_address[9:0]] <= mem_dataIn;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Mutual exclusion of grants and read-valids on every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check_val("gnt_mutex", 32'(gnt0 && gnt1), 32'd0);
      check_val("rvalid_mutex", 32'(rvalid0 && rvalid1), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    step();
    step();
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  function automatic logic sel_bit(input int port, input logic b0, input logic b1);
    return (port == 0) ? b0 : b1;
  endfunction

  // One single-port transaction with full handshake and response checks.
  task automatic run_txn(input int port, input logic we, input logic [A-1:0] addr,
                         input logic [W-1:0] wdata, input logic [W-1:0] exp_rd,
                         input logic exp_err);
    logic got;
    int   n;
    logic [W-1:0] rd;
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end
    got = 1'b0;
    n = 0;
    while (!got && n < 4) begin
      step();
      n++;
      got = sel_bit(port, gnt0, gnt1);
    end
    check_val("gnt_seen", 32'(got), 32'd1);
    check_val("gnt_latency", 32'(n), 32'd1);
    check_val("we_exec", 32'(mem_writeEn), 32'(we && !exp_err));
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    check_val("gnt_drop", 32'(sel_bit(port, gnt0, gnt1)), 32'd0);
    check_val("rvalid", 32'(sel_bit(port, rvalid0, rvalid1)), 32'(!we));
    check_val("rvalid_other", 32'(sel_bit(1 - port, rvalid0, rvalid1)), 32'd0);
    check_val("err", 32'(sel_bit(port, err0, err1)), 32'(exp_err));
    rd = (port == 0) ? rdata0 : rdata1;
    if (!we) begin
      check_val("rdata", 32'(rd), 32'(exp_rd));
      last_rd[port] = exp_rd;
    end else begin
      check_val("rdata_hold", 32'(rd), 32'(last_rd[port]));
    end
  endtask

  initial begin
    logic [W-1:0] exp_d;
    int pidx;
    for (int i = 0; i < N; i++) mem[i] = '0;

    // Reset state
    do_reset();
    check_val("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    check_val("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    check_val("rst_err", 32'({err1, err0}), 32'd0);
    check_val("rst_rdata0", 32'(rdata0), 32'd0);
    check_val("rst_rdata1", 32'(rdata1), 32'd0);
    check_val("rst_mem_bus", 32'({mem_writeEn, mem_address}), 32'd0);

    // Port 0 write, then port 1 read-back
    run_txn(0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0);
    check_val("mem5", 32'(mem[5]), 32'h0000BEEF);
    run_txn(1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0);

    // Continuous contention after reset: 0,1,0,1 one per two cycles
    mem[1] = 16'h1111;
    mem[2] = 16'h2222;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
    for (int i = 1; i <= 8; i++) begin
      step();
      pidx = ((i - 1) / 2) % 2;
      if (i % 2 == 1) begin
        check_val("rr_gnt0", 32'(gnt0), 32'(pidx == 0));
        check_val("rr_gnt1", 32'(gnt1), 32'(pidx == 1));
      end else begin
        check_val("rr_rvalid0", 32'(rvalid0), 32'(pidx == 0));
        check_val("rr_rvalid1", 32'(rvalid1), 32'(pidx == 1));
        check_val("rr_gnt_idle", 32'({gnt1, gnt0}), 32'd0);
        if (pidx == 0) check_val("rr_rdata0", 32'(rdata0), 32'h00001111);
        else           check_val("rr_rdata1", 32'(rdata1), 32'h00002222);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    last_rd[0] = 16'h1111;
    last_rd[1] = 16'h2222;

    // Out-of-range write and read
    mem[0] = 16'h5A5A;
    run_txn(0, 1'b1, 16'h0400, 16'h1234, 16'h0000, 1'b1);
    check_val("oor_mem0", 32'(mem[0]), 32'h00005A5A);
    run_txn(0, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1);

    // Reset during EXEC of a write aborts it cleanly
    mem[3] = 16'h3333;
    mem[7] = 16'h0000;
    run_txn(0, 1'b0, 16'h0003, 16'h0000, 16'h3333, 1'b0);
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0007; wdata0 = 16'hAAAA;
    step();
    check_val("abort_gnt0", 32'(gnt0), 32'd1);
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    check_val("abort_we", 32'(mem_writeEn), 32'd0);
    step();
    rst = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    check_val("abort_gnt", 32'({gnt1, gnt0}), 32'd0);
    check_val("abort_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    check_val("abort_err", 32'({err1, err0}), 32'd0);
    check_val("abort_rdata0", 32'(rdata0), 32'd0);
    check_val("abort_mem7", 32'(mem[7]), 32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
    step();
    check_val("post_abort_gnt0", 32'(gnt0), 32'd1);
    check_val("post_abort_gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    check_val("post_abort_rdata0", 32'(rdata0), 32'h00001111);
    last_rd[0] = 16'h1111;
    step();

    // Random serial traffic against a scoreboard of the low 16 words
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      sb[i]  = '0;
    end
    for (int t = 0; t < 40; t++) begin
      int   p;
      logic w;
      logic oor;
      logic [3:0] a;
      logic [W-1:0] d;
      p   = int'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      a   = 4'($urandom_range(0, 15));
      oor = ($urandom_range(0, 5) == 0);
      d   = 16'($urandom);
      exp_d = oor ? 16'h0000 : sb[a];
      run_txn(p, w, oor ? (16'h0400 | 16'(a)) : 16'(a), d, exp_d, oor);
      if (w && !oor) sb[a] = d;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
